// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall vector, one-cycle flush on exception, redirect target.
// Optional memory-stall watchdog compiled in with `define PIPE_CTRL_WDT_EN.
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h00000020,
   parameter logic [7:0]  WDT_LIMIT  = 8'd16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_id,
   input  logic        stallreq_from_ex,
   input  logic        stallreq_from_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        bus_timeout
);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   state_e      state_q;
   state_e      state_d;
   logic [31:0] new_pc_q;
   logic [31:0] new_pc_d;
   logic        exc_s;
   logic        eret_s;
   logic        expire_s;

   if ((WDT_LIMIT < 8'd2) || (WDT_LIMIT > 8'd255)) begin : g_bad_wdt_limit
      $error("pipe_ctrl: WDT_LIMIT must lie in 2..255");
   end

   assign exc_s  = (excepttype_i != 32'h00000000);
   assign eret_s = (excepttype_i == 32'h0000000e);

`ifdef PIPE_CTRL_WDT_EN
   logic [7:0] wdt_q;
   logic [7:0] wdt_d;
   logic       bus_timeout_q;
   logic       bus_timeout_d;

   assign expire_s = (state_q == ST_RUN) && stallreq_from_mem &&
                     (wdt_q == (WDT_LIMIT - 8'd1));

   // Watchdog counts only uninterrupted RUN-state memory stalls.
   always_comb begin
      wdt_d         = 8'h00;
      bus_timeout_d = 1'b0;
      if ((state_q == ST_RUN) && stallreq_from_mem && !exc_s && !expire_s) begin
         wdt_d = wdt_q + 8'd1;
      end else begin
         wdt_d = 8'h00;
      end
      bus_timeout_d = expire_s;
   end

   // Watchdog state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdt_q         <= 8'h00;
         bus_timeout_q <= 1'b0;
      end else begin
         wdt_q         <= wdt_d;
         bus_timeout_q <= bus_timeout_d;
      end
   end

   assign bus_timeout = bus_timeout_q;
`else
   assign expire_s    = 1'b0;
   assign bus_timeout = 1'b0;
`endif

   // Hold vector: mem > ex > id, suppressed in FLUSH and while reset is low.
   always_comb begin
      stall = 6'b000000;
      if (!rst || (state_q != ST_RUN)) begin
         stall = 6'b000000;
      end else if (stallreq_from_mem) begin
         stall = 6'b011111;
      end else if (stallreq_from_ex) begin
         stall = 6'b001111;
      end else if (stallreq_from_id) begin
         stall = 6'b000111;
      end else begin
         stall = 6'b000000;
      end
   end

   // Next state and redirect target; a real exception wins the target over a timeout.
   always_comb begin
      state_d  = ST_RUN;
      new_pc_d = 32'h00000000;
      case (state_q)
         ST_RUN: begin
            if (exc_s) begin
               state_d  = ST_FLUSH;
               new_pc_d = eret_s ? cp0_epc_i : EXC_VECTOR;
            end else if (expire_s) begin
               state_d  = ST_FLUSH;
               new_pc_d = EXC_VECTOR;
            end else begin
               state_d  = ST_RUN;
               new_pc_d = 32'h00000000;
            end
         end
         ST_FLUSH: begin
            state_d  = ST_RUN;
            new_pc_d = 32'h00000000;
         end
         default: begin
            state_d  = ST_RUN;
            new_pc_d = 32'h00000000;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_RUN;
         new_pc_q <= 32'h00000000;
      end else begin
         state_q  <= state_d;
         new_pc_q <= new_pc_d;
      end
   end

   assign flush  = (state_q == ST_FLUSH);
   assign new_pc = new_pc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; watchdog checks follow PIPE_CTRL_WDT_EN.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        stallreq_from_id;
   logic        stallreq_from_ex;
   logic        stallreq_from_mem;
   logic [31:0] excepttype_i;
   logic [31:0] cp0_epc_i;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        bus_timeout;

   int checks;
   int errors;

   pipe_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .stallreq_from_id  (stallreq_from_id),
      .stallreq_from_ex  (stallreq_from_ex),
      .stallreq_from_mem (stallreq_from_mem),
      .excepttype_i      (excepttype_i),
      .cp0_epc_i         (cp0_epc_i),
      .stall             (stall),
      .flush             (flush),
      .new_pc            (new_pc),
      .bus_timeout       (bus_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks            = 0;
      errors            = 0;
      rst               = 1'b0;
      stallreq_from_id  = 1'b0;
      stallreq_from_ex  = 1'b0;
      stallreq_from_mem = 1'b1;
      excepttype_i      = 32'h00000000;
      cp0_epc_i         = 32'h00000000;
      #3;
      chk("rst_stall", {26'h0, stall}, 32'h00000000);
      chk("rst_flush", {31'h0, flush}, 32'h00000000);
      chk("rst_newpc", new_pc, 32'h00000000);
      chk("rst_bto", {31'h0, bus_timeout}, 32'h00000000);
      stallreq_from_mem = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("idle_stall", {26'h0, stall}, 32'h00000000);
      chk("idle_flush", {31'h0, flush}, 32'h00000000);
      chk("idle_newpc", new_pc, 32'h00000000);

      // Stall priority.
      stallreq_from_id = 1'b1; stallreq_from_ex = 1'b1; stallreq_from_mem = 1'b1;
      #1 chk("stall_all", {26'h0, stall}, 32'h0000001f);
      stallreq_from_mem = 1'b0;
      #1 chk("stall_ex_id", {26'h0, stall}, 32'h0000000f);
      stallreq_from_ex = 1'b0;
      #1 chk("stall_id", {26'h0, stall}, 32'h00000007);
      stallreq_from_id = 1'b0;
      #1 chk("stall_none", {26'h0, stall}, 32'h00000000);

      // Exception beats memory stall.
      excepttype_i = 32'h00000001; stallreq_from_mem = 1'b1;
      #1 chk("pre_exc_stall", {26'h0, stall}, 32'h0000001f);
      tick();
      excepttype_i = 32'h00000000;
      #1;
      chk("exc_flush", {31'h0, flush}, 32'h00000001);
      chk("exc_newpc", new_pc, 32'h00000020);
      chk("exc_stall", {26'h0, stall}, 32'h00000000);
      tick();
      chk("exc_flush_end", {31'h0, flush}, 32'h00000000);
      chk("exc_newpc_end", new_pc, 32'h00000000);
      chk("exc_stall_back", {26'h0, stall}, 32'h0000001f);
      stallreq_from_mem = 1'b0;

      // Eret held two cycles: single flush pulse.
      excepttype_i = 32'h0000000e; cp0_epc_i = 32'h00001234;
      tick();
      chk("eret_flush", {31'h0, flush}, 32'h00000001);
      chk("eret_newpc", new_pc, 32'h00001234);
      tick();
      excepttype_i = 32'h00000000;
      #1;
      chk("eret_flush_end", {31'h0, flush}, 32'h00000000);
      chk("eret_newpc_end", new_pc, 32'h00000000);
      tick();
      chk("eret_no_second", {31'h0, flush}, 32'h00000000);

      // Asynchronous reset mid-flush.
      excepttype_i = 32'h00000005;
      tick();
      excepttype_i = 32'h00000000;
      stallreq_from_mem = 1'b1;
      chk("arst_pre_flush", {31'h0, flush}, 32'h00000001);
      #2 rst = 1'b0;
      #1;
      chk("arst_flush", {31'h0, flush}, 32'h00000000);
      chk("arst_newpc", new_pc, 32'h00000000);
      chk("arst_stall", {26'h0, stall}, 32'h00000000);
      stallreq_from_mem = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      excepttype_i = 32'h00000003;
      tick();
      excepttype_i = 32'h00000000;
      chk("arst_run_exc", {31'h0, flush}, 32'h00000001);
      tick();
      chk("arst_run_end", {31'h0, flush}, 32'h00000000);

`ifdef PIPE_CTRL_WDT_EN
      // Sixteen-cycle memory stall expires the watchdog.
      stallreq_from_mem = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick();
         chk("wdt_quiet", {30'h0, bus_timeout, flush}, 32'h00000000);
      end
      tick();
      stallreq_from_mem = 1'b0;
      chk("wdt_bto", {31'h0, bus_timeout}, 32'h00000001);
      chk("wdt_flush", {31'h0, flush}, 32'h00000001);
      chk("wdt_newpc", new_pc, 32'h00000020);
      tick();
      chk("wdt_bto_end", {30'h0, bus_timeout, flush}, 32'h00000000);
      // Fifteen-cycle stall then release: no pulse.
      stallreq_from_mem = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick();
      end
      stallreq_from_mem = 1'b0;
      tick();
      chk("wdt_15_none", {30'h0, bus_timeout, flush}, 32'h00000000);
      // Expiry coinciding with eret: eret target, pulse still fires.
      stallreq_from_mem = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick();
      end
      excepttype_i = 32'h0000000e; cp0_epc_i = 32'h00000040;
      tick();
      excepttype_i = 32'h00000000; stallreq_from_mem = 1'b0;
      chk("wdt_exc_bto", {31'h0, bus_timeout}, 32'h00000001);
      chk("wdt_exc_newpc", new_pc, 32'h00000040);
      tick();
`else
      // Without the watchdog a memory stall may persist indefinitely.
      stallreq_from_mem = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         chk("nowdt_hold", {24'h0, bus_timeout, flush, stall}, 32'h0000001f);
      end
      stallreq_from_mem = 1'b0;
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
